pipelined_block_adder: RTL and testbench

//   Parametrised pipelined add/subtract unit, successor to the fixed 32-bit 8-bit-block adders.

---
 rtl/pipelined_block_adder.sv | 134 +++++++++++++
 tb/tb_pipelined_block_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_block_adder.sv
// Pipelined add/subtract unit: the operand is resolved one BLOCK-bit slice per stage.
// The carry is registered between stages, and a valid/ready handshake stalls the whole pipe.
module pipelined_block_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTAGE = WIDTH / BLOCK;

    if (WIDTH % BLOCK != 0) begin : g_bad_param
        $error("pipelined_block_adder: WIDTH must be a multiple of BLOCK");
    end

    // Taps of each stage's registers; the last stage carries no operands forward.
    logic             stage_valid [NSTAGE];
    logic [WIDTH-1:0] stage_a     [NSTAGE];
    logic [WIDTH-1:0] stage_b     [NSTAGE];
    logic [WIDTH-1:0] stage_sum   [NSTAGE];
    logic             stage_carry [NSTAGE];
    logic             ovf_reg;
    logic             advance;

    // One global enable: a held result freezes every stage, bubbles included.
    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_stage
        logic             src_valid;
        logic             src_carry;
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic [BLOCK:0]   slice_add;
        logic [WIDTH-1:0] sum_next;
        logic             valid_reg;
        logic [WIDTH-1:0] sum_reg;
        logic             carry_reg;

        if (gi == 0) begin : g_first
            // Subtraction is A + ~B + 1, so the carry-in is forced high.
            assign src_valid = in_valid;
            assign src_a     = a;
            assign src_b     = sub ? ~b : b;
            assign src_carry = sub | cin;
            assign src_sum   = '0;
        end else begin : g_next
            assign src_valid = stage_valid[gi-1];
            assign src_a     = stage_a[gi-1];
            assign src_b     = stage_b[gi-1];
            assign src_carry = stage_carry[gi-1];
            assign src_sum   = stage_sum[gi-1];
        end

        assign slice_add = {1'b0, src_a[gi*BLOCK +: BLOCK]}
                         + {1'b0, src_b[gi*BLOCK +: BLOCK]}
                         + {{BLOCK{1'b0}}, src_carry};

        always_comb begin
            sum_next = src_sum;
            sum_next[gi*BLOCK +: BLOCK] = slice_add[BLOCK-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_reg <= 1'b0;
                sum_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (advance) begin
                valid_reg <= src_valid;
                if (src_valid) begin
                    sum_reg   <= sum_next;
                    carry_reg <= slice_add[BLOCK];
                end
            end
        end

        assign stage_valid[gi] = valid_reg;
        assign stage_sum[gi]   = sum_reg;
        assign stage_carry[gi] = carry_reg;

        if (gi < NSTAGE - 1) begin : g_mid
            logic [WIDTH-1:0] a_reg;
            logic [WIDTH-1:0] b_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (advance && src_valid) begin
                    a_reg <= src_a;
                    b_reg <= src_b;
                end
            end

            assign stage_a[gi] = a_reg;
            assign stage_b[gi] = b_reg;
        end else begin : g_last
            logic ovf_next;

            // Carry into the MSB is recovered from the MSB sum bit and its operands.
            assign ovf_next = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ sum_next[WIDTH-1]
                            ^ slice_add[BLOCK];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_reg <= 1'b0;
                end else if (advance && src_valid) begin
                    ovf_reg <= ovf_next;
                end
            end

            assign stage_a[gi] = '0;
            assign stage_b[gi] = '0;
        end
    end

    assign out_valid = stage_valid[NSTAGE-1];
    assign sum       = stage_sum[NSTAGE-1];
    assign cout      = stage_carry[NSTAGE-1];
    assign ovf       = ovf_reg;
endmodule

// File: tb/tb_pipelined_block_adder.sv
// Scoreboard bench for pipelined_block_adder in the 32/8, 16/4 and 8/8 configurations.
// Expected results come from plain signed/unsigned integer arithmetic.
module tb_pipelined_block_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit done [3];

    typedef struct {
        logic [63:0]     s;
        bit              co;
        bit              ov;
        longint unsigned acc_cyc;
        longint unsigned acc_stall;
    } exp_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: the true integer result, reduced mod 2^w, with range-based flags.
    function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input bit c, input bit s_mode,
                                  output logic [63:0] s, output bit co, output bit ov);
        longint ua, ub, sa, sb, sr, full, mask, lim;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        ua   = longint'(av);
        ub   = longint'(bv);
        sa   = (ua >= lim) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= lim) ? ub - (longint'(1) << w) : ub;
        if (s_mode) begin
            full = ua - ub;
            co   = (ua >= ub);
            sr   = sa - sb;
        end else begin
            full = ua + ub + longint'(c);
            co   = (full > mask);
            sr   = sa + sb + longint'(c);
        end
        s  = 64'(full & mask);
        ov = (sr > lim - 1) || (sr < -lim);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int W  = (gi == 0) ? 32 : (gi == 1) ? 16 : 8;
        localparam int B  = (gi == 0) ? 8  : (gi == 1) ? 4  : 8;
        localparam int NS = W / B;
        localparam logic [W-1:0] MINNEG = {1'b1, {(W-1){1'b0}}};
        localparam logic [W-1:0] MAXPOS = {1'b0, {(W-1){1'b1}}};
        localparam logic [W-1:0] ALL1   = {W{1'b1}};
        localparam int NRAND = 10000;

        logic         rst_n = 1'b0;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         cin = 1'b0;
        logic         sub = 1'b0;
        logic         out_valid;
        logic         out_ready = 1'b0;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;

        bit              rand_ready = 1'b0;
        exp_t            sb_q[$];
        longint unsigned cyc = 0;
        longint unsigned stalls = 0;
        bit              prev_stall = 1'b0;
        logic [W+1:0]    prev_out = '0;

        pipelined_block_adder #(.WIDTH(W), .BLOCK(B)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cin(cin), .sub(sub),
            .out_valid(out_valid), .out_ready(out_ready),
            .sum(sum), .cout(cout), .ovf(ovf)
        );

        always @(posedge clk) cyc <= cyc + 1;

        always begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 99) < 70);
        end

        // Monitor: inputs change only just after posedge, so negedge values hold to the next edge.
        always @(negedge clk) begin : mon
            exp_t e;
            bit   stall;
            if (!rst_n) begin
                prev_stall <= 1'b0;
            end else begin
                stall = out_valid && !out_ready;
                check($sformatf("w%0d_in_ready", W), 64'(in_ready), 64'(!stall));
                if (prev_stall)
                    check($sformatf("w%0d_stall_hold", W), 64'({out_valid, cout, ovf, sum}),
                          64'({1'b1, prev_out}));
                if (in_valid && in_ready) begin
                    model(W, 64'(a), 64'(b), cin, sub, e.s, e.co, e.ov);
                    e.acc_cyc   = cyc;
                    e.acc_stall = stalls;
                    sb_q.push_back(e);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL w%0d_unexpected_out actual=%0h required=none", W, sum);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("w%0d_sum", W), 64'(sum), e.s);
                        check($sformatf("w%0d_cout", W), 64'(cout), 64'(e.co));
                        check($sformatf("w%0d_ovf", W), 64'(ovf), 64'(e.ov));
                        check($sformatf("w%0d_latency", W), 64'(cyc - e.acc_cyc),
                              64'(longint'(NS) + stalls - e.acc_stall));
                    end
                end
                stalls     <= stalls + 64'(stall);
                prev_stall <= stall;
                prev_out   <= {cout, ovf, sum};
            end
        end

        task automatic idle(input int n);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        endtask

        task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vc, input logic vs);
            bit acc = 1'b0;
            in_valid = 1'b1;
            a = va;
            b = vb;
            cin = vc;
            sub = vs;
            for (int i = 0; i < 2000 && !acc; i++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            if (!acc) begin
                checks++;
                failures++;
                $display("FAIL w%0d_accept_timeout actual=not_accepted required=accepted", W);
            end
        endtask

        function automatic logic [W-1:0] rnd_operand();
            case ($urandom_range(0, 7))
                0:       return ALL1;
                1:       return MINNEG;
                2:       return MAXPOS;
                default: return W'($urandom);
            endcase
        endfunction

        initial begin : drv
            repeat (3) @(posedge clk);
            #3 rst_n = 1'b1;
            @(negedge clk);
            check($sformatf("w%0d_rst_in_ready", W), 64'(in_ready), 64'd1);
            check($sformatf("w%0d_rst_out_valid", W), 64'(out_valid), 64'd0);
            check($sformatf("w%0d_rst_outputs", W), 64'({cout, ovf, sum}), 64'd0);
            @(posedge clk);
            #1;
            out_ready = 1'b1;

            // Directed corners: full ripple, borrow / no borrow, signed overflow both ways.
            send(ALL1, W'(1), 1'b0, 1'b0);
            send(W'(5), W'(7), 1'b1, 1'b1);
            send(W'(7), W'(5), 1'b0, 1'b1);
            send(MAXPOS, W'(1), 1'b0, 1'b0);
            send(MINNEG, W'(1), 1'b0, 1'b1);
            send(W'(3), W'(4), 1'b1, 1'b0);
            idle(NS + 4);

            // Back-to-back beats with a 3-cycle stall when the first result appears.
            fork
                for (int i = 1; i <= 6; i++) send(W'(i), W'(i), 1'b0, 1'b0);
                begin
                    for (int i = 0; i < 50 && !out_valid; i++) idle(1);
                    out_ready = 1'b0;
                    idle(3);
                    out_ready = 1'b1;
                end
            join
            idle(NS + 4);

            // Fill the pipe against a blocked output, then reset between edges.
            out_ready = 1'b0;
            for (int i = 0; i < NS; i++) send(W'($urandom), W'($urandom), 1'b0, 1'b0);
            @(posedge clk);
            #3 rst_n = 1'b0;
            #1;
            check($sformatf("w%0d_async_rst_valid", W), 64'(out_valid), 64'd0);
            check($sformatf("w%0d_async_rst_outputs", W), 64'({cout, ovf, sum}), 64'd0);
            sb_q.delete();
            @(posedge clk);
            #3 rst_n = 1'b1;
            out_ready = 1'b1;
            idle(2 * NS + 5);
            send(W'(9), W'(6), 1'b1, 1'b0);
            idle(NS + 2);

            rand_ready = 1'b1;
            for (int n = 0; n < NRAND; n++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send(rnd_operand(), rnd_operand(), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end

            rand_ready = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 500 && sb_q.size() != 0; i++) idle(1);
            checks++;
            if (sb_q.size() != 0) begin
                failures++;
                $display("FAIL w%0d_drain actual=%0d_pending required=0", W, sb_q.size());
            end
            done[gi] = 1'b1;
        end
    end

    initial begin : finisher
        for (int i = 0; i < 95000 && !(done[0] && done[1] && done[2]); i++) @(posedge clk);
        if (!(done[0] && done[1] && done[2])) begin
            checks++;
            failures++;
            $display("FAIL run_timeout actual=%0d%0d%0d required=111", done[0], done[1], done[2]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
